// File: rtl/preg_alloc_queue.sv
// Physical-register allocation queue: buffers free tags offered by the free
// list and hands up to W of them per cycle to rename, oldest first.

package uop_pkg;
    localparam int INSTR_Q_WIDTH = 2;
endpackage

package reg_pkg;
    localparam int NUM_PHYS_REGS = 64;
endpackage

// Per-lane address generation: read slot for regs_out and write slot/enable
// for the lane of the free-list offer.
module preg_alloc_lane #(
    parameter int LANE = 0,
    parameter int AW   = 4,
    parameter int KW   = 3
) (
    input  logic [AW-1:0] head,
    input  logic [AW-1:0] tail,
    input  logic          take,
    input  logic [KW-1:0] k,
    output logic [AW-1:0] rd_idx,
    output logic [AW-1:0] wr_idx,
    output logic          wr_en
);
    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign rd_idx = head + AW'(LANE);
    assign wr_idx = tail + AW'(LANE);
    // Only the low k lanes are taken, so the accept mask stays contiguous.
    assign wr_en  = take && (KW'(LANE) < k);
endmodule

module preg_alloc_queue #(
    parameter  int DEPTH = 16,
    localparam int W     = 2*uop_pkg::INSTR_Q_WIDTH+2,
    localparam int PW    = $clog2(reg_pkg::NUM_PHYS_REGS),
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH+1),
    localparam int KW    = $clog2(W+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frl_valid_in,
    input  logic [W-1:0][PW-1:0]  frl_regs_in,
    output logic [W-1:0]          frl_accept_out,
    input  logic                  req_valid_in,
    input  logic [KW-1:0]         req_count_in,
    output logic                  grant_out,
    output logic [W-1:0][PW-1:0]  regs_out,
    output logic [CW-1:0]         count_out
);
    typedef enum logic {TAKE, ACK} state_t;

    state_t         state;
    logic [PW-1:0]  mem [DEPTH];
    logic [AW-1:0]  head, tail;
    logic [CW-1:0]  count;
    logic [CW-1:0]  space;
    logic [KW-1:0]  k;
    logic           take;
    logic [KW-1:0]  push_n, pop_n;

    logic [W-1:0][AW-1:0] rd_idx, wr_idx;
    logic [W-1:0]         wr_en;

    // Space is measured before this cycle's pop; grant uses occupancy before
    // this cycle's push, so neither side sees a same-cycle effect.
    always_comb begin
        space = CW'(DEPTH) - count;
        k     = (space >= CW'(W)) ? KW'(W) : space[KW-1:0];
        take  = (state == TAKE) && frl_valid_in && (space != '0);
    end

    // All-or-nothing grant; requests wider than the lane count never grant.
    always_comb begin
        grant_out = req_valid_in && (req_count_in != '0) &&
                    (req_count_in <= KW'(W)) && (CW'(req_count_in) <= count);
        pop_n     = grant_out ? req_count_in : '0;
        push_n    = take ? k : '0;
    end

    genvar g;
    generate
        for (g = 0; g < W; g++) begin : g_lane
            preg_alloc_lane #(.LANE(g), .AW(AW), .KW(KW)) u_lane (
                .head   (head),
                .tail   (tail),
                .take   (take),
                .k      (k),
                .rd_idx (rd_idx[g]),
                .wr_idx (wr_idx[g]),
                .wr_en  (wr_en[g])
            );
            assign regs_out[g] = mem[rd_idx[g]];
        end
    endgenerate

    // Tag storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (wr_en[i]) mem[wr_idx[i]] <= frl_regs_in[i];
        end
    end

    // TAKE/ACK handshake: after a take, one ACK cycle presents the mask so the
    // same offer is never taken twice before the free list advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= TAKE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            frl_accept_out <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
            case (state)
                TAKE: begin
                    frl_accept_out <= take ? wr_en : '0;
                    state          <= take ? ACK : TAKE;
                end
                default: begin
                    frl_accept_out <= '0;
                    state          <= TAKE;
                end
            endcase
        end
    end

    assign count_out = count;
endmodule
